// File: rtl/cmp_seq.sv
// rtl/cmp_seq.sv - multi-cycle MSB-first magnitude comparator, DIGIT bits per clock
module cmp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sign_flip;
  logic [IDXW-1:0]  idx;
  logic [DIGIT-1:0] a_top;
  logic [DIGIT-1:0] b_top;
  logic             load;
  logic             decide;

  // Operands are shifted left each cycle so the chunk under test is always at the top.
  assign a_top     = a_sh[WIDTH-1 -: DIGIT];
  assign b_top     = b_sh[WIDTH-1 -: DIGIT];
  assign sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    decide  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if ((a_top != b_top) || (idx == '0)) begin
          decide  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = SCAN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == SCAN);
      done  <= (state_n == DONE);
      if (load) begin
        // Inverting both MSBs maps two's-complement order onto unsigned order.
        a_sh <= a ^ sign_flip;
        b_sh <= b ^ sign_flip;
        idx  <= IDXW'(NCHUNK - 1);
      end else if (state == SCAN) begin
        a_sh <= a_sh << DIGIT;
        b_sh <= b_sh << DIGIT;
        idx  <= idx - 1'b1;
      end
      if (decide) begin
        gt <= (a_top > b_top);
        lt <= (a_top < b_top);
        eq <= (a_top == b_top);
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// tb/tb_cmp_seq.sv - self-checking bench for cmp_seq at DIGIT = 1, 2 and 8
module tb_cmp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] start_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [2:0] gt_w;
  logic [2:0] lt_w;
  logic [2:0] eq_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cmp_seq #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start_w[0]), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .lt(lt_w[0]), .eq(eq_w[0]));
  cmp_seq #(.WIDTH(8), .DIGIT(2)) dut_d2 (
    .clk(clk), .rst(rst), .start(start_w[1]), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .lt(lt_w[1]), .eq(eq_w[1]));
  cmp_seq #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .start(start_w[2]), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .gt(gt_w[2]), .lt(lt_w[2]), .eq(eq_w[2]));

  function automatic int dig_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer ordering, latency from the first differing chunk counted from the top.
  function automatic void model(input int d, input logic [7:0] av, input logic [7:0] bv,
                                input logic sm, output logic egt, output logic elt,
                                output logic eeq, output int lat);
    int dig, nch, ai, bi, sa, sb;
    dig = dig_of(d);
    nch = 8 / dig;
    ai  = int'(av);
    bi  = int'(bv);
    sa  = (sm && ai >= 128) ? ai - 256 : ai;
    sb  = (sm && bi >= 128) ? bi - 256 : bi;
    egt = (sa > sb);
    elt = (sa < sb);
    eeq = (sa == sb);
    lat = nch;
    for (int k = nch - 1; k >= 0; k--) begin
      if (((ai >> (k * dig)) & ((1 << dig) - 1)) != ((bi >> (k * dig)) & ((1 << dig) - 1))) begin
        lat = nch - k;
        break;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the DONE cycle.
  task automatic do_cmp(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input bit poke, input string tag);
    logic egt, elt, eeq;
    int   lat, n;
    model(d, av, bv, sm, egt, elt, eeq, lat);
    a = av;
    b = bv;
    signed_mode = sm;
    start_w[d] = 1'b1;
    @(negedge clk);
    start_w[d] = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    signed_mode = 1'($urandom);
    n = 0;
    while (done_w[d] !== 1'b1 && n < 20) begin
      check({tag, " busy"}, 32'(busy_w[d]), 32'd1);
      start_w[d] = (poke && n == 1);
      @(negedge clk);
      n++;
    end
    start_w[d] = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy_at_done"}, 32'(busy_w[d]), 32'd0);
    check({tag, " flags"}, {29'd0, gt_w[d], lt_w[d], eq_w[d]}, {29'd0, egt, elt, eeq});
  endtask

  task automatic idle_gap(input int d, input string tag);
    logic [2:0] held;
    held = {gt_w[d], lt_w[d], eq_w[d]};
    @(negedge clk);
    check({tag, " idle_busy_done"}, {30'd0, busy_w[d], done_w[d]}, 32'd0);
    check({tag, " flags_held"}, {29'd0, gt_w[d], lt_w[d], eq_w[d]}, {29'd0, held});
  endtask

  initial begin
    rst = 1'b1;
    start_w = '0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy_w), 32'd0);
    check("reset done", 32'(done_w), 32'd0);
    check("reset flags", {23'd0, gt_w, lt_w, eq_w}, 32'd0);

    for (int d = 0; d < 3; d++) begin
      do_cmp(d, 8'h80, 8'h01, 1'b0, 1'b0, "u80_01"); idle_gap(d, "u80_01");
      do_cmp(d, 8'h80, 8'h01, 1'b1, 1'b0, "s80_01"); idle_gap(d, "s80_01");
      do_cmp(d, 8'h80, 8'hFF, 1'b0, 1'b0, "u80_ff"); idle_gap(d, "u80_ff");
      do_cmp(d, 8'h80, 8'hFF, 1'b1, 1'b0, "s80_ff"); idle_gap(d, "s80_ff");
      do_cmp(d, 8'h80, 8'h80, 1'b0, 1'b0, "eq80");   idle_gap(d, "eq80");
      do_cmp(d, 8'h12, 8'h13, 1'b0, 1'b0, "u12_13"); idle_gap(d, "u12_13");
    end

    do_cmp(1, 8'h80, 8'h80, 1'b0, 1'b1, "poke");
    do_cmp(1, 8'h05, 8'h03, 1'b0, 1'b0, "b2b");

    // Abort on the second SCAN cycle; gt from the b2b result must be wiped.
    a = 8'h80; b = 8'h80; signed_mode = 1'b0; start_w[1] = 1'b1;
    @(negedge clk);
    start_w[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort outputs", {27'd0, busy_w[1], done_w[1], gt_w[1], lt_w[1], eq_w[1]}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort no_done", 32'(done_w[1]), 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 60; i++) begin
      int         d;
      logic [7:0] av, bv;
      d  = int'($urandom_range(2));
      av = 8'($urandom);
      case ($urandom_range(3))
        0:       bv = av;
        1:       bv = av ^ (8'd1 << $urandom_range(7));
        default: bv = 8'($urandom);
      endcase
      do_cmp(d, av, bv, 1'($urandom), 1'b0, "rand");
      if ($urandom_range(1) == 0) idle_gap(d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
